// File: rtl/alu_wb.sv
// Writeback / flag-commit stage: 2-entry in-order queue behind the ALU, conditional commit.
// Define ALU_WB_FWD_EN to expose the committing write on the fwd_* bypass outputs.
module alu_wb #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_o,
    input  logic          in_c,
    input  logic          in_z,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic [1:0]    in_cond,
    input  logic          in_fl,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic          rf_ready,
    output logic          flag_c,
    output logic          flag_z,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data
);

    logic [DW-1:0] q_o    [2];
    logic          q_c    [2];
    logic          q_z    [2];
    logic [RW-1:0] q_rd   [2];
    logic          q_we   [2];
    logic [1:0]    q_cond [2];
    logic          q_fl   [2];

    logic       head;
    logic       tail;
    logic [1:0] count;

    logic head_valid;
    logic pass;
    logic accept;
    logic retire;

    assign head_valid = (count != 2'd0);
    assign in_ready   = (count < 2'd2);
    assign accept     = in_valid & in_ready;

    // Condition is judged against the flags as they stand now, so an entry
    // sees the flag update of the entry that retired just before it.
    always_comb begin
        pass = 1'b0;
        case (q_cond[head])
            2'b00:   pass = 1'b1;
            2'b01:   pass = flag_c;
            2'b10:   pass = flag_z;
            default: pass = 1'b0;
        endcase
    end

    assign rf_we    = head_valid & pass & q_we[head];
    assign rf_waddr = q_rd[head];
    assign rf_wdata = q_o[head];
    assign retire   = (rf_we & rf_ready) | (head_valid & ~(pass & q_we[head]));

    // Payload storage needs no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_o[tail]    <= in_o;
            q_c[tail]    <= in_c;
            q_z[tail]    <= in_z;
            q_rd[tail]   <= in_rd;
            q_we[tail]   <= in_we;
            q_cond[tail] <= in_cond;
            q_fl[tail]   <= in_fl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            if (accept) tail <= ~tail;
            if (retire) head <= ~head;
            case ({accept, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (retire && pass && q_fl[head]) begin
                flag_c <= q_c[head];
                flag_z <= q_z[head];
            end
        end
    end

`ifdef ALU_WB_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_rd    = q_rd[head];
    assign fwd_data  = q_o[head];
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_wb.sv
// Scoreboard bench for alu_wb: expected writes are queued at accept and checked by a monitor.
module tb_alu_wb;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_o;
    logic          in_c;
    logic          in_z;
    logic [RW-1:0] in_rd;
    logic          in_we;
    logic [1:0]    in_cond;
    logic          in_fl;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_ready;
    logic          flag_c;
    logic          flag_z;
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;

    alu_wb #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_o(in_o), .in_c(in_c), .in_z(in_z), .in_rd(in_rd),
        .in_we(in_we), .in_cond(in_cond), .in_fl(in_fl),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .flag_c(flag_c), .flag_z(flag_z),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        bit            chkLat;
        int            expCycle;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one entry; expWrite marks the hand-derived outcome of its condition.
    task automatic applyStimulus(input logic [DW-1:0] o, input logic c, input logic z,
                                 input logic [RW-1:0] rd, input logic we, input logic [1:0] cond,
                                 input logic fl, input bit expWrite, input bit chkLat);
        int budget;
        wr_t e;
        in_valid = 1'b1;
        in_o = o; in_c = c; in_z = z; in_rd = rd; in_we = we; in_cond = cond; in_fl = fl;
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (expWrite) begin
            e.rd = rd; e.data = o; e.chkLat = chkLat; e.expCycle = cycle;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop on each accepted write, check hold-while-stalled and forwarding.
    logic          prevStall = 1'b0;
    logic [RW-1:0] prevAddr;
    logic [DW-1:0] prevData;
    wr_t           got;

    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_we", {31'd0, rf_we}, 32'd1);
                checkOutput("stall_addr", {29'd0, rf_waddr}, {29'd0, prevAddr});
                checkOutput("stall_data", {16'd0, rf_wdata}, {16'd0, prevData});
            end
            if (rf_we && rf_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_write: got r%0d=0x%0h, expected no write", rf_waddr, rf_wdata);
                end else begin
                    got = sb.pop_front();
                    checkOutput("wr_addr", {29'd0, rf_waddr}, {29'd0, got.rd});
                    checkOutput("wr_data", {16'd0, rf_wdata}, {16'd0, got.data});
                    if (got.chkLat) checkOutput("wr_latency", cycle, got.expCycle);
                end
            end
            prevStall = rf_we && !rf_ready;
            prevAddr  = rf_waddr;
            prevData  = rf_wdata;
        end
`ifdef ALU_WB_FWD_EN
        checkOutput("fwd_valid", {31'd0, fwd_valid}, {31'd0, rf_we});
        if (rf_we) begin
            checkOutput("fwd_rd", {29'd0, fwd_rd}, {29'd0, rf_waddr});
            checkOutput("fwd_data", {16'd0, fwd_data}, {16'd0, rf_wdata});
        end
`else
        checkOutput("fwd_zero", {12'd0, fwd_valid, fwd_rd, fwd_data}, 32'd0);
`endif
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_o = '0; in_c = 1'b0; in_z = 1'b0; in_rd = '0;
        in_we = 1'b0; in_cond = 2'b00; in_fl = 1'b0; rf_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_flags", {30'd0, flag_c, flag_z}, 32'd0);

        // Back-to-back unconditional writes, one per cycle
        applyStimulus(16'h0001, 1'b0, 1'b0, 3'd1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h8000, 1'b0, 1'b0, 3'd2, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b1, 3'd3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
        idle(3);
        checkOutput("s1_flags", {30'd0, flag_c, flag_z}, 32'd3);
        checkOutput("s1_drained", sb.size(), 32'd0);

        // Clear flags, then carry-conditional write that passes
        applyStimulus(16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle(2);
        checkOutput("clr_flags", {30'd0, flag_c, flag_z}, 32'd0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h1234, 1'b0, 1'b0, 3'd4, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        idle(3);
        checkOutput("s2a_drained", sb.size(), 32'd0);

        // Same with carry cleared: B annulled, its flag payload ignored
        applyStimulus(16'h0000, 1'b0, 1'b1, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h1234, 1'b1, 1'b0, 3'd4, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        idle(3);
        checkOutput("s2b_flags", {30'd0, flag_c, flag_z}, 32'd1);

        // Never-condition entries retire without rf_ready
        rf_ready = 1'b0;
        applyStimulus(16'h5555, 1'b1, 1'b0, 3'd5, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h5555, 1'b1, 1'b0, 3'd5, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("s3_in_ready_a", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'h5555, 1'b1, 1'b0, 3'd6, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("s3_in_ready_b", {31'd0, in_ready}, 32'd1);
        idle(1);
        checkOutput("s3_flags", {30'd0, flag_c, flag_z}, 32'd1);

        // Back-pressure: fill the queue while the register file stalls
        applyStimulus(16'hA5A5, 1'b0, 1'b0, 3'd5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h5A5A, 1'b0, 1'b0, 3'd6, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("s4_full", {31'd0, in_ready}, 32'd0);
        fork
            applyStimulus(16'h0F0F, 1'b0, 1'b0, 3'd7, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        join_none
        idle(2);
        checkOutput("s4_still_full", {31'd0, in_ready}, 32'd0);
        checkOutput("s4_head_addr", {29'd0, rf_waddr}, 32'd5);
        rf_ready = 1'b1;
        wait fork;
        idle(4);
        checkOutput("s4_drained", sb.size(), 32'd0);

        // Reset with a full queue and both flags set
        applyStimulus(16'h0000, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        rf_ready = 1'b0;
        applyStimulus(16'h1111, 1'b0, 1'b0, 3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h2222, 1'b0, 1'b0, 3'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_pre_full", {31'd0, in_ready}, 32'd0);
        checkOutput("s5_pre_flags", {30'd0, flag_c, flag_z}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("s5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("s5_rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
        idle(1);
        rst = 1'b0;
        rf_ready = 1'b1;
        applyStimulus(16'hBEEF, 1'b1, 1'b0, 3'd3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
        idle(3);
        checkOutput("s5_post_flags", {30'd0, flag_c, flag_z}, 32'd2);
        checkOutput("final_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
